// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
//  Module      : change_dispenser
//  Description : Pays change back to the coin hopper one coin at a time,
//                largest available coin first, and flags a shortfall.
//  Revision    : 1.0  initial release
// ============================================================================
module change_dispenser #(
  parameter int AMT_W   = 4,
  parameter int STOCK_W = 4,
  parameter int INIT_C1 = 8,
  parameter int INIT_C2 = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [AMT_W-1:0]   change_amt,
  input  logic               hopper_ready,
  input  logic               clear,
  input  logic               refill,
  output logic [1:0]         coin_out,
  output logic               coin_valid,
  output logic               busy,
  output logic               done,
  output logic               short_err,
  output logic [AMT_W-1:0]   remaining,
  output logic [STOCK_W-1:0] stock_c1,
  output logic [STOCK_W-1:0] stock_c2
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEL   = 3'd1,
    S_ISSUE = 3'd2,
    S_DONE  = 3'd3,
    S_SHORT = 3'd4
  } state_t;

  localparam logic [1:0]         c_coin_none = 2'b00;
  localparam logic [1:0]         c_coin_5    = 2'b01;
  localparam logic [1:0]         c_coin_10   = 2'b10;
  localparam logic [STOCK_W-1:0] c_init_c1   = STOCK_W'(INIT_C1);
  localparam logic [STOCK_W-1:0] c_init_c2   = STOCK_W'(INIT_C2);
  localparam logic [AMT_W-1:0]   c_amt_one   = AMT_W'(1);
  localparam logic [AMT_W-1:0]   c_amt_two   = AMT_W'(2);
  localparam logic [STOCK_W-1:0] c_stock_one = STOCK_W'(1);

  state_t             r_state;
  logic [1:0]         r_coin;
  logic [AMT_W-1:0]   r_remaining;
  logic [STOCK_W-1:0] r_stock_c1;
  logic [STOCK_W-1:0] r_stock_c2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_coin      <= c_coin_none;
      r_remaining <= '0;
      r_stock_c1  <= c_init_c1;
      r_stock_c2  <= c_init_c2;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_remaining <= change_amt;
            r_state     <= S_SEL;
          end else if (refill) begin
            r_stock_c1 <= c_init_c1;
            r_stock_c2 <= c_init_c2;
          end
        end
        // A coin type is picked only while its stock is non-zero, so stocks cannot underflow.
        S_SEL: begin
          if (r_remaining == '0) begin
            r_state <= S_DONE;
          end else if (r_remaining >= c_amt_two && r_stock_c2 != '0) begin
            r_coin  <= c_coin_10;
            r_state <= S_ISSUE;
          end else if (r_stock_c1 != '0) begin
            r_coin  <= c_coin_5;
            r_state <= S_ISSUE;
          end else begin
            r_state <= S_SHORT;
          end
        end
        S_ISSUE: begin
          if (hopper_ready) begin
            if (r_coin == c_coin_10) begin
              r_remaining <= r_remaining - c_amt_two;
              r_stock_c2  <= r_stock_c2 - c_stock_one;
            end else begin
              r_remaining <= r_remaining - c_amt_one;
              r_stock_c1  <= r_stock_c1 - c_stock_one;
            end
            r_coin  <= c_coin_none;
            r_state <= S_SEL;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        S_SHORT: begin
          if (clear) begin
            r_remaining <= '0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_coin  <= c_coin_none;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign coin_out   = r_coin;
  assign coin_valid = (r_state == S_ISSUE);
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign short_err  = (r_state == S_SHORT);
  assign remaining  = r_remaining;
  assign stock_c1   = r_stock_c1;
  assign stock_c2   = r_stock_c2;

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_change_dispenser
//  Description : Directed self-checking bench with a coin scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_change_dispenser;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] change_amt;
  logic       hopper_ready;
  logic       clear;
  logic       refill;
  logic [1:0] coin_out;
  logic       coin_valid;
  logic       busy;
  logic       done;
  logic       short_err;
  logic [3:0] remaining;
  logic [3:0] stock_c1;
  logic [3:0] stock_c2;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  change_dispenser #(
    .AMT_W(4), .STOCK_W(4), .INIT_C1(8), .INIT_C2(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .change_amt(change_amt),
    .hopper_ready(hopper_ready), .clear(clear), .refill(refill),
    .coin_out(coin_out), .coin_valid(coin_valid), .busy(busy), .done(done),
    .short_err(short_err), .remaining(remaining),
    .stock_c1(stock_c1), .stock_c2(stock_c2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [3:0] amt);
    change_amt = amt;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    chk(tag, 32'(done), 32'd1);
    step();
    chk({tag, "_one_cycle"}, 32'(done), 32'd0);
  endtask

  // Scoreboard: a coin is accepted on the edge following a cycle with valid && ready.
  always @(negedge clk) begin
    if (!reset && coin_valid === 1'b1 && hopper_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_coin", 32'(coin_out), 32'd0);
        if (coin_out == 2'b00) begin
          errors++;
          $error("FAIL unexpected_coin observed=valid expected=no_coin");
        end
      end else begin
        chk("coin", 32'(coin_out), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; change_amt = '0; hopper_ready = 1'b0;
    clear = 1'b0; refill = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("rst_busy",      32'(busy),       32'd0);
    chk("rst_valid",     32'(coin_valid), 32'd0);
    chk("rst_coin",      32'(coin_out),   32'd0);
    chk("rst_done",      32'(done),       32'd0);
    chk("rst_short",     32'(short_err),  32'd0);
    chk("rst_remaining", 32'(remaining),  32'd0);
    chk("rst_c1",        32'(stock_c1),   32'd8);
    chk("rst_c2",        32'(stock_c2),   32'd4);

    // 1: amount 3 -> 10-unit then 5-unit
    hopper_ready = 1'b1;
    exp_q.push_back(2'b10); exp_q.push_back(2'b01);
    pulse_start(4'd3);
    wait_done("t1_done");
    chk("t1_c2",   32'(stock_c2),     32'd3);
    chk("t1_c1",   32'(stock_c1),     32'd7);
    chk("t1_rem",  32'(remaining),    32'd0);
    chk("t1_q",    32'(exp_q.size()), 32'd0);

    // 2: hopper stalls for 5 cycles
    hopper_ready = 1'b0;
    pulse_start(4'd2);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t2_valid", 32'(coin_valid), 32'd1);
      chk("t2_coin",  32'(coin_out),   32'd2);
      chk("t2_rem",   32'(remaining),  32'd2);
      step();
    end
    exp_q.push_back(2'b10);
    hopper_ready = 1'b1;
    wait_done("t2_done");
    chk("t2_rem_end", 32'(remaining), 32'd0);

    // 3: from fresh stock, drain 10-unit coins then fall back to 5-unit coins
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(2'b10);
    pulse_start(4'd8);
    wait_done("t3a_done");
    exp_q.push_back(2'b01); exp_q.push_back(2'b01);
    pulse_start(4'd2);
    wait_done("t3b_done");
    chk("t3_c2", 32'(stock_c2), 32'd0);
    chk("t3_c1", 32'(stock_c1), 32'd6);

    // 4: drain to one 5-unit coin, then request 3 -> shortfall of 2
    for (int i = 0; i < 5; i++) exp_q.push_back(2'b01);
    pulse_start(4'd5);
    wait_done("t4a_done");
    chk("t4_c1_pre", 32'(stock_c1), 32'd1);
    exp_q.push_back(2'b01);
    pulse_start(4'd3);
    begin
      int n = 0;
      while (short_err !== 1'b1 && n < 30) begin step(); n++; end
    end
    chk("t4_short", 32'(short_err), 32'd1);
    chk("t4_rem",   32'(remaining), 32'd2);
    chk("t4_c1",    32'(stock_c1),  32'd0);
    step();
    chk("t4_short_hold", 32'(short_err), 32'd1);
    clear = 1'b1; step(); clear = 1'b0;
    chk("t4_short_clr", 32'(short_err), 32'd0);
    chk("t4_busy_clr",  32'(busy),      32'd0);
    chk("t4_rem_clr",   32'(remaining), 32'd0);
    chk("t4_q",         32'(exp_q.size()), 32'd0);

    // refill in IDLE restores stock
    refill = 1'b1; step(); refill = 1'b0;
    chk("refill_c1", 32'(stock_c1), 32'd8);
    chk("refill_c2", 32'(stock_c2), 32'd4);

    // 5: reset during ISSUE abandons the coin and restores stock
    exp_q.push_back(2'b01);
    pulse_start(4'd1);
    wait_done("t5a_done");
    chk("t5_c1_pre", 32'(stock_c1), 32'd7);
    hopper_ready = 1'b0;
    pulse_start(4'd2);
    step();
    chk("t5_issue", 32'(coin_valid), 32'd1);
    reset = 1'b1; step(); reset = 1'b0;
    chk("t5_valid", 32'(coin_valid), 32'd0);
    chk("t5_busy",  32'(busy),       32'd0);
    chk("t5_c1",    32'(stock_c1),   32'd8);
    chk("t5_c2",    32'(stock_c2),   32'd4);

    // 6: zero amount -> done without any coin
    hopper_ready = 1'b1;
    pulse_start(4'd0);
    chk("t6_sel_done",  32'(done),       32'd0);
    chk("t6_sel_valid", 32'(coin_valid), 32'd0);
    step();
    chk("t6_done",      32'(done),       32'd1);
    chk("t6_valid",     32'(coin_valid), 32'd0);
    step();
    chk("t6_idle",      32'(busy),       32'd0);

    // start/refill/change_amt while busy are ignored
    hopper_ready = 1'b0;
    pulse_start(4'd4);
    step();
    change_amt = 4'd15; start = 1'b1; refill = 1'b1;
    step(); step();
    start = 1'b0; refill = 1'b0;
    chk("t6_busy_rem", 32'(remaining), 32'd4);
    chk("t6_busy_c2",  32'(stock_c2),  32'd4);
    exp_q.push_back(2'b10); exp_q.push_back(2'b10);
    hopper_ready = 1'b1;
    wait_done("t6b_done");
    chk("t6_end_c2",  32'(stock_c2), 32'd2);
    chk("t6_end_c1",  32'(stock_c1), 32'd8);
    chk("t6_end_rem", 32'(remaining), 32'd0);
    chk("final_q",    32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
